// File: rtl/sdram_port_arb.sv
// sdram_port_arb: two-port round-robin arbiter serialising commands to one SDRAM controller,
// returning read data and a completion pulse to the owner, with a sticky timeout on a silent controller.
module sdram_port_arb #(
    parameter int AW      = 21,
    parameter int TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          boot_done,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_be,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_be,
    output logic          m0_ack,
    output logic [31:0]   m0_rdata,
    output logic          m1_ack,
    output logic [31:0]   m1_rdata,
    output logic          s_req,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_wdata,
    output logic [3:0]    s_be,
    input  logic          s_ack,
    input  logic [31:0]   s_rdata,
    output logic [1:0]    grant,
    output logic          timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [11:0]   cnt_q, cnt_d;
    logic          s_req_q, s_req_d, s_we_q, s_we_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [31:0]   s_wdata_q, s_wdata_d;
    logic [3:0]    s_be_q, s_be_d;
    logic          m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic [31:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [1:0]    grant_q, grant_d;
    logic          terr_q, terr_d;
    logic          e1, pick1, tmo;

    // port 1 only competes after boot; on a tie the port that was not served last wins
    assign e1    = m1_req & boot_done;
    assign pick1 = e1 & (~m0_req | ~last_q);
    assign tmo   = cnt_q == 12'(TIMEOUT - 1);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        s_req_d    = s_req_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_be_d     = s_be_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        grant_d    = grant_q;
        terr_d     = terr_q;
        case (state_q)
            IDLE: if (m0_req | e1) begin
                s_we_d    = pick1 ? m1_we : m0_we;
                s_addr_d  = pick1 ? m1_addr : m0_addr;
                s_wdata_d = pick1 ? m1_wdata : m0_wdata;
                s_be_d    = pick1 ? m1_be : m0_be;
                grant_d   = pick1 ? 2'b10 : 2'b01;
                s_req_d   = 1'b1;
                cnt_d     = '0;
                state_d   = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q + 12'd1;
                if (s_ack | tmo) begin
                    s_req_d    = 1'b0;
                    terr_d     = terr_q | ~s_ack;
                    m0_ack_d   = grant_q[0];
                    m1_ack_d   = grant_q[1];
                    m0_rdata_d = grant_q[0] ? (s_ack ? s_rdata : 32'h0) : m0_rdata_q;
                    m1_rdata_d = grant_q[1] ? (s_ack ? s_rdata : 32'h0) : m1_rdata_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_be_q     <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            grant_q    <= 2'b00;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            s_req_q    <= s_req_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_be_q     <= s_be_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            grant_q    <= grant_d;
            terr_q     <= terr_d;
        end
    end

    assign s_req       = s_req_q;
    assign s_we        = s_we_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_be        = s_be_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign grant       = grant_q;
    assign timeout_err = terr_q;
endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Two-requester arbiter in front of the single-command SDRAM controller in `example_soc`. It shares the Tang Nano 20K 32-bit SDRAM between two masters:
- port 0: the SD-card boot loader DMA;
- port 1: the Hazard3 CPU bus bridge.

It serialises one command at a time, latches the winning command, and returns read data and a completion pulse to the owner. A timeout guards against a hung controller.

## Interface
Parameters:
- `AW`, 21: SDRAM word-address width (2M x 32).
- `TIMEOUT`, 4095: max cycles to wait for `s_ack`, 1..4095.

Ports:
- `clk` in 1: system clock (`pll_clk` domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `boot_done` in 1: 0 = only port 0 may be granted; 1 = round-robin between both ports.
- `m0_req`, `m1_req` in 1: request; held high with fields stable until the matching `mN_ack`.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in AW: word address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_be`, `m1_be` in 4: byte enables.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out 32: read data; valid while `mN_ack`=1 and held until that port's next ack.
- `s_req` out 1: command to controller; held until `s_ack` or timeout.
- `s_we` out 1, `s_addr` out AW, `s_wdata` out 32, `s_be` out 4: latched command.
- `s_ack` in 1: controller completion pulse; `s_rdata` is valid in the same cycle.
- `s_rdata` in 32: controller read data.
- `grant` out 2: one-hot current owner, 00 when idle.
- `timeout_err` out 1: sticky; set on any timeout; cleared only by reset.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Sample requests. Eligible = `m0_req`, plus `m1_req` only if `boot_done`=1.
  - Arbitration: round-robin, with `last` = port most recently acked (reset value 1, so port 0 wins first).
    - Both eligible: grant the port ≠ `last`.
    - One eligible: grant it.
  - On grant: latch we/addr/wdata/be into the `s_*` registers, set `grant`, load the timeout counter with 0, go to BUSY.
  - `s_ack` seen in IDLE or DONE is a stale ack and is ignored.
- BUSY:
  - `s_req`=1; counter increments each cycle.
  - On `s_ack`: capture `s_rdata` into the owner's `mN_rdata` (also on writes) → DONE.
  - Counter reaches `TIMEOUT` without `s_ack`: `s_req`←0, owner's `mN_rdata`←0, `timeout_err`←1 → DONE.
  - Owner dropping `mN_req` while BUSY is ignored; the latched command completes.
- DONE:
  - `mN_ack`=1 for the owner for this single cycle; `last`←owner; `grant`←00 → IDLE.
  - A requester still asserting req in the cycle after its ack is issuing a new transaction.
- `boot_done` falling while BUSY: the in-flight command completes; it affects only later arbitration.
- Reset asserted mid-transaction: all state clears immediately, no ack is issued, and the SDRAM controller is reset by the same `rst_n`.

## Timing
- Reset values: `s_req`=0, `s_we`=0, `s_addr`=0, `s_wdata`=0, `s_be`=0, `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0, `grant`=00, `timeout_err`=0, state=IDLE, `last`=1.
- All outputs are registered.
- Request path:
  - Cycle N: `mN_req` high in IDLE.
  - Cycle N+1: `s_req`, `s_*` and `grant` valid.
- Completion path: `s_ack` at cycle K → `mN_ack` and `mN_rdata` at K+1 → IDLE at K+2.
- Minimum occupancy is 3 cycles per transaction (IDLE, BUSY, DONE); `s_ack` in the first BUSY cycle is legal.
- Throughput: back-to-back requests from one port, with the other idle, issue every (controller latency + 2) cycles.
- Timeout: `s_req` high for exactly `TIMEOUT` cycles, then `mN_ack` on the next cycle.
- `s_req` never goes from 1 to 0 to 1 without passing through DONE and IDLE.

## Test plan
- Reset with `boot_done`=0; `m0_req` write addr 0x000010, wdata 0xA5A5A5A5, be 0xF; controller acks 5 cycles after `s_req` → `s_addr`=0x000010 at N+1, `m0_ack` one pulse 1 cycle after `s_ack`, `grant`=01 during BUSY.
- `boot_done`=0, `m1_req` held 50 cycles → `s_req` stays 0 and `m1_ack` never pulses. Then `boot_done`=1 → grant 10 within 1 cycle.
- `boot_done`=1, both ports request continuously, reads, controller acks with 0x11111111 (port0 cmd) / 0x22222222 (port1 cmd) → grants alternate 01,10,01,10 over 4 transactions; each `mN_rdata` matches its own data.
- `TIMEOUT`=16, controller never acks → `s_req` high for exactly 16 cycles, `m1_ack` with `m1_rdata`=0, `timeout_err`=1. A late `s_ack` in IDLE causes no ack and no state change.
- `rst_n` pulsed low 2 cycles after `s_req` rises → all outputs return to reset values asynchronously, no `mN_ack`, `last`=1 afterwards.
- Port 0 drops `m0_req` in BUSY → command still completes and `m0_ack` is issued; port 0 re-asserts req the cycle after ack → second transaction issued.
